// File: rtl/param_one_port_mem_if.sv
// Bus bundle for the one-port memory model.
// master: the access initiator (drives address, controls, write data, OEN).
// slave:  the memory (drives Q, QVALID, BUSY, ERR).
// Signals: a (word address), cen/wen/bwen/oen (active-low controls),
//          d (write data), q (gated read data), qvalid, busy, err.
interface param_one_port_mem_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
);
    logic [AW-1:0]      a;
    logic               cen;
    logic               wen;
    logic [WIDTH/8-1:0] bwen;
    logic [WIDTH-1:0]   d;
    logic               oen;
    logic [WIDTH-1:0]   q;
    logic               qvalid;
    logic               busy;
    logic               err;

    modport master (
        output a, cen, wen, bwen, d, oen,
        input  q, qvalid, busy, err
    );

    modport slave (
        input  a, cen, wen, bwen, d, oen,
        output q, qvalid, busy, err
    );
endinterface

// File: rtl/param_one_port_mem.sv
// Parametrised single-port synchronous memory model.
// Ports:
//   clk       - clock, all state on the rising edge
//   rst_n     - asynchronous active-low reset
//   bus       - slave side of param_one_port_mem_if (a, cen, wen, bwen, d, oen in;
//               q, qvalid, busy, err out)
//   state_dbg - current FSM state (0 = INIT walk, 1 = IDLE)
//
// Access handshake: there is no ready signal. An access is accepted on a rising
// edge when cen=0 and busy=0; while busy=1 every access is silently dropped.
// A read returns its data RD_LAT edges later (the accepting edge counts as the
// first), marked by a one-cycle qvalid pulse; reads are accepted every cycle.
module param_one_port_mem #(
    parameter int              WIDTH      = 8,
    parameter int              DEPTH      = 256,
    parameter int              AW         = 8,
    parameter int              RD_LAT     = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    param_one_port_mem_if.slave bus,
    output logic                state_dbg
);
    localparam int NB = WIDTH / 8;
    // AW+1 bits so DEPTH = 2**AW is representable without wrapping.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

    generate
        if ((WIDTH % 8) != 0) begin : g_bad_width
            $error("param_one_port_mem: WIDTH must be a multiple of 8");
        end
        if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_lat
            $error("param_one_port_mem: RD_LAT must be in 1..4");
        end
        if (DEPTH > (2 ** AW)) begin : g_bad_depth
            $error("param_one_port_mem: DEPTH must not exceed 2**AW");
        end
    endgenerate

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [AW:0]      cnt;
    logic [AW:0]      cnt_next;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             in_range;
    logic             rd_req;
    logic             wr_req;
    logic [WIDTH-1:0] rd_data;

    // Read pipe: stage 0 loads on the accepting edge; the last stage doubles
    // as q_reg because its data only moves when a valid read arrives.
    logic [RD_LAT-1:0] pipe_v;
    logic [WIDTH-1:0]  pipe_d [RD_LAT];
    logic              err_q;

    assign accept   = !bus.cen && (state == ST_IDLE);
    assign in_range = {1'b0, bus.a} < DEPTH_W;
    assign rd_req   = accept && bus.wen;
    assign wr_req   = accept && !bus.wen && in_range;
    // Out-of-range reads travel the normal pipe as zero.
    assign rd_data  = in_range ? mem[bus.a] : '0;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // FSM next state: walk cnt through 0..DEPTH-1 once, then sit in IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_INIT: begin
                cnt_next = cnt + 1'b1;
                if (cnt == LAST_W) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // Storage is deliberately not reset; the init walk fills it instead.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[cnt[AW-1:0]] <= INIT_VALUE;
        end else if (wr_req) begin
            for (int i = 0; i < NB; i++) begin
                if (!bus.bwen[i]) begin
                    mem[bus.a][8*i +: 8] <= bus.d[8*i +: 8];
                end
            end
        end
    end

    // Read pipe and error strobe. Reads sample mem before this edge's write,
    // so a read sees old data for a location written on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_d[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            pipe_v[0] <= rd_req;
            if (rd_req) begin
                pipe_d[0] <= rd_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_d[i] <= pipe_d[i-1];
                end
            end
            err_q <= accept && !in_range;
        end
    end

    // OEN gates only the visible output, never the held value.
    assign bus.q      = bus.oen ? '0 : pipe_d[RD_LAT-1];
    assign bus.qvalid = pipe_v[RD_LAT-1];
    assign bus.busy   = (state == ST_INIT);
    assign bus.err    = err_q;
    assign state_dbg  = state;
endmodule

// File: tb/tb_param_one_port_mem.sv
// Self-checking bench for param_one_port_mem (WIDTH=32, DEPTH=200, RD_LAT=3).
module tb_param_one_port_mem;
    localparam int              W     = 32;
    localparam int              DEPTH = 200;
    localparam int              AW    = 8;
    localparam int              LAT   = 3;
    localparam int              NB    = W / 8;
    localparam logic [W-1:0]    INIT  = 32'hC0DE_0001;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic state_dbg;
    always #5 clk = ~clk;

    param_one_port_mem_if #(.WIDTH(W), .AW(AW)) bus ();

    param_one_port_mem #(
        .WIDTH(W), .DEPTH(DEPTH), .AW(AW), .RD_LAT(LAT), .INIT_VALUE(INIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .state_dbg(state_dbg)
    );

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Memory contents as an array, in-flight reads as (data, due-edge) queues.
    logic [W-1:0] mem_m [DEPTH];
    logic [W-1:0] exp_q[$];
    int           due_q[$];
    int           init_left = DEPTH;
    int           cyc = 0;
    logic [W-1:0] q_m = '0;
    logic         qv_m = 1'b0;
    logic         err_m = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_left = DEPTH;
            exp_q.delete();
            due_q.delete();
            q_m   = '0;
            qv_m  = 1'b0;
            err_m = 1'b0;
        end else begin
            qv_m  = 1'b0;
            err_m = 1'b0;
            if (init_left > 0) begin
                mem_m[DEPTH - init_left] = INIT;
                init_left--;
            end else if (!bus.cen) begin
                if (int'(bus.a) >= DEPTH) err_m = 1'b1;
                if (bus.wen) begin
                    exp_q.push_back((int'(bus.a) < DEPTH) ? mem_m[bus.a] : '0);
                    due_q.push_back(cyc + LAT - 1);
                end else if (int'(bus.a) < DEPTH) begin
                    for (int i = 0; i < NB; i++) begin
                        if (!bus.bwen[i]) mem_m[bus.a][8*i +: 8] = bus.d[8*i +: 8];
                    end
                end
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                q_m = exp_q.pop_front();
                void'(due_q.pop_front());
                qv_m = 1'b1;
            end
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            check("busy",   W'(bus.busy),   W'(init_left > 0));
            check("qvalid", W'(bus.qvalid), W'(qv_m));
            check("err",    W'(bus.err),    W'(err_m));
            check("q",      bus.q,          bus.oen ? '0 : q_m);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic c, input logic w, input logic [AW-1:0] av,
                        input logic [W-1:0] dv, input logic [NB-1:0] bw);
        @(negedge clk);
        bus.cen  = c;
        bus.wen  = w;
        bus.a    = av;
        bus.d    = dv;
        bus.bwen = bw;
    endtask

    task automatic idle();
        step(1'b1, 1'b1, '0, '0, '1);
    endtask

    task automatic wr(input logic [AW-1:0] av, input logic [W-1:0] dv, input logic [NB-1:0] bw);
        step(1'b0, 1'b0, av, dv, bw);
    endtask

    task automatic rd(input logic [AW-1:0] av);
        step(1'b0, 1'b1, av, '0, '1);
    endtask

    // Issue one read and watch a fixed window for its qvalid pulse(s).
    task automatic read_word(input logic [AW-1:0] av, output logic [W-1:0] data, output int pulses);
        data   = '0;
        pulses = 0;
        rd(av);
        for (int k = 0; k < 8; k++) begin
            idle();
            #2;
            if (bus.qvalid) begin
                pulses++;
                data = bus.q;
            end
        end
    endtask

    // Called right after releasing reset on a falling edge.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            #2;
            if (!bus.busy) break;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [W-1:0] data;
        int           pulses;
        int           n;

        bus.cen  = 1'b1;
        bus.wen  = 1'b1;
        bus.a    = '0;
        bus.d    = '0;
        bus.bwen = '1;
        bus.oen  = 1'b0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);

        // reset / init walk
        rst_n = 1'b1;
        count_busy(n);
        check("init_cycles", W'(n), W'(200));
        read_word(8'h37, data, pulses);
        check("init_value", data, 32'hC0DE_0001);
        check("init_read_pulses", W'(pulses), W'(1));

        // byte-lane writes
        wr(8'd5, 32'hAABB_CCDD, 4'b0000);
        wr(8'd5, 32'h1122_3344, 4'b1010);
        read_word(8'd5, data, pulses);
        check("byte_merge", data, 32'hAA22_CC44);

        // latency and streaming
        wr(8'd1, 32'h01, 4'b0000);
        wr(8'd2, 32'h02, 4'b0000);
        wr(8'd3, 32'h03, 4'b0000);
        rd(8'd1);
        rd(8'd2);
        rd(8'd3);
        #2 check("stream_early_qvalid", W'(bus.qvalid), W'(0));
        idle();
        #2 check("stream_qv0", W'(bus.qvalid), W'(1));
        check("stream_q0", bus.q, 32'h01);
        idle();
        #2 check("stream_qv1", W'(bus.qvalid), W'(1));
        check("stream_q1", bus.q, 32'h02);
        idle();
        #2 check("stream_qv2", W'(bus.qvalid), W'(1));
        check("stream_q2", bus.q, 32'h03);
        idle();
        #2 check("stream_end", W'(bus.qvalid), W'(0));
        check("stream_hold", bus.q, 32'h03);

        // out of range
        wr(8'd210, 32'hDEAD_BEEF, 4'b0000);
        idle();
        #2 check("oor_write_err", W'(bus.err), W'(1));
        rd(8'd210);
        idle();
        #2 check("oor_read_err", W'(bus.err), W'(1));
        idle();
        idle();
        #2 check("oor_read_qv", W'(bus.qvalid), W'(1));
        check("oor_read_q", bus.q, 32'h0);

        // output enable gating, mid-cycle
        wr(8'd7, 32'h5A, 4'b0000);
        read_word(8'd7, data, pulses);
        check("oen_setup", data, 32'h5A);
        @(negedge clk);
        #3 bus.oen = 1'b1;
        #1 check("oen_off", bus.q, 32'h0);
        #1 bus.oen = 1'b0;
        #1 check("oen_on", bus.q, 32'h5A);

        // read followed by write to the same word
        wr(8'd9, 32'h10, 4'b0000);
        rd(8'd9);
        wr(8'd9, 32'h20, 4'b0000);
        idle();
        idle();
        #2 check("coll_old", bus.q, 32'h10);
        read_word(8'd9, data, pulses);
        check("coll_new", data, 32'h20);

        // randomized traffic, checked every cycle by the compare process
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 3) == 0), 1'(($urandom_range(0, 1))),
                 AW'($urandom_range(0, 215)), W'($urandom), NB'($urandom_range(0, 15)));
            bus.oen = ($urandom_range(0, 4) == 0);
        end
        idle();
        bus.oen = 1'b0;
        repeat (4) idle();

        // reset with a read in flight: it must never surface
        rd(8'd3);
        idle();
        #2 rst_n = 1'b0;
        #1 check("rst_qvalid", W'(bus.qvalid), W'(0));
        check("rst_q", bus.q, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset partway through the walk, then a full walk again
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midinit_busy", W'(bus.busy), W'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        check("reinit_cycles", W'(n), W'(200));
        read_word(8'd9, data, pulses);
        check("reinit_value", data, 32'hC0DE_0001);

        repeat (2) idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
